bfly_seq: RTL and testbench

BFLY_SEQ -- requirements
Module: bfly_seq

---
 rtl/fp_pkg.sv | 29 ++
 rtl/bfly_addsub.sv | 21 ++
 rtl/fp_add32.sv | 65 ++++++
 rtl/bfly_seq.sv | 109 ++++++++++
 tb/tb_bfly_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field layout and sequencer state encoding for the
// butterfly datapath.
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MAN_HI   = 22;
  localparam int MAN_LO   = 0;
  localparam int EXP_W    = EXP_HI - EXP_LO + 1;
  localparam int MAN_W    = MAN_HI - MAN_LO + 1;

  localparam logic [31:0]      FP_ZERO = 32'h0000_0000;
  localparam logic [31:0]      FP_NAN  = 32'hFFFF_FFFF;
  localparam logic [EXP_W-1:0] EXP_INF = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RE   = 2'd1,
    ST_IM   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

endpackage

// File: rtl/bfly_addsub.sv
// Shared butterfly arithmetic: selects the real or imaginary operand pair and
// feeds the single adder and single subtractor.
module bfly_addsub
  import fp_pkg::*;
(
  input  cplx_t       a_i,
  input  cplx_t       b_i,
  input  logic        sel_im_i,
  output logic [31:0] sum_o,
  output logic [31:0] diff_o
);

  logic [31:0] op_a, op_b;

  assign op_a = sel_im_i ? a_i.im : a_i.re;
  assign op_b = sel_im_i ? b_i.im : b_i.re;

  fp_add32 #(.SUB(1'b0)) u_add (.a_i(op_a), .b_i(op_b), .y_o(sum_o));
  fp_add32 #(.SUB(1'b1)) u_sub (.a_i(op_a), .b_i(op_b), .y_o(diff_o));

endmodule

// File: rtl/fp_add32.sv
// Combinational single-precision adder; SUB=1 negates B to form a subtractor.
// Denormals flush to zero, results truncate, overflow and Inf/NaN inputs give FP_NAN.
module fp_add32
  import fp_pkg::*;
#(
  parameter bit SUB = 1'b0
) (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic              sa, sb, sl, ss, a_big, eff_sub, sticky;
  logic [EXP_W-1:0]  ea, eb, el, es, ediff;
  logic [MAN_W:0]    man_a, man_b, ml, ms;
  logic [MAN_W+3:0]  ml_x, ms_x, ms_sh;
  logic [MAN_W+4:0]  mag, norm;
  logic [4:0]        lz;
  logic signed [9:0] exp_r;
  logic [MAN_W-1:0]  mant;

  always_comb begin
    sa     = a_i[SIGN_BIT];
    sb     = b_i[SIGN_BIT] ^ SUB;
    ea     = a_i[EXP_HI:EXP_LO];
    eb     = b_i[EXP_HI:EXP_LO];
    man_a  = (ea != '0) ? {1'b1, a_i[MAN_HI:MAN_LO]} : '0;
    man_b  = (eb != '0) ? {1'b1, b_i[MAN_HI:MAN_LO]} : '0;
    a_big  = a_i[EXP_HI:MAN_LO] >= b_i[EXP_HI:MAN_LO];
    sl     = a_big ? sa : sb;
    ss     = a_big ? sb : sa;
    el     = a_big ? ea : eb;
    es     = a_big ? eb : ea;
    ml     = a_big ? man_a : man_b;
    ms     = a_big ? man_b : man_a;
    ediff  = el - es;
    ml_x   = {ml, 3'b000};
    ms_x   = {ms, 3'b000};
    sticky = 1'b0;
    // three guard bits plus a sticky LSB keep borrows right on subtraction
    if (ediff >= 8'd27) begin
      ms_sh = {26'd0, |ms_x};
    end else begin
      ms_sh     = ms_x >> ediff;
      sticky    = |(ms_x & ((27'd1 << ediff) - 27'd1));
      ms_sh[0]  = ms_sh[0] | sticky;
    end
    eff_sub = sl ^ ss;
    mag     = eff_sub ? ({1'b0, ml_x} - {1'b0, ms_sh})
                      : ({1'b0, ml_x} + {1'b0, ms_sh});
    lz = 5'd0;
    for (int i = 0; i < 28; i++) begin
      if (mag[i]) lz = 5'(27 - i);
    end
    norm  = mag << lz;
    exp_r = $signed({2'b00, el}) + 10'sd1 - $signed({5'd0, lz});
    mant  = 23'(norm >> 4);
    if (ea == EXP_INF || eb == EXP_INF) y_o = FP_NAN;
    else if (mag == '0)                 y_o = FP_ZERO;
    else if (exp_r >= 10'sd255)         y_o = FP_NAN;
    else if (exp_r <= 10'sd0)           y_o = FP_ZERO;
    else                                y_o = {sl, exp_r[7:0], mant};
  end

endmodule

// File: rtl/bfly_seq.sv
// Radix-2 butterfly sequencer: captures A/B, computes the real half then the
// imaginary half on one shared add/sub pair, and holds results until taken.
module bfly_seq
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a_re,
  input  logic [31:0]      a_im,
  input  logic [31:0]      b_re,
  input  logic [31:0]      b_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      s_re,
  output logic [31:0]      s_im,
  output logic [31:0]      d_re,
  output logic [31:0]      d_im,
  output logic             busy,
  output logic [CNT_W-1:0] bfly_cnt
);

  state_e             state_q, state_d;
  cplx_t              a_q, b_q;
  logic [31:0]        s_re_q, s_im_q, d_re_q, d_im_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, sel_im, ld_re, ld_im;
  logic [31:0]        sum, diff;

  bfly_addsub u_addsub (
    .a_i      (a_q),
    .b_i      (b_q),
    .sel_im_i (sel_im),
    .sum_o    (sum),
    .diff_o   (diff)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    sel_im   = 1'b0;
    ld_re    = 1'b0;
    ld_im    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RE;
      end
      ST_RE: begin
        ld_re   = 1'b1;
        state_d = ST_IM;
      end
      ST_IM: begin
        sel_im  = 1'b1;
        ld_im   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // results leave and a new set may enter on the same edge
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? ST_RE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign cnt_d     = (out_valid && out_ready) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_re_q  <= FP_ZERO;
      s_im_q  <= FP_ZERO;
      d_re_q  <= FP_ZERO;
      d_im_q  <= FP_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q <= '{re: a_re, im: a_im};
        b_q <= '{re: b_re, im: b_im};
      end
      if (ld_re) begin
        s_re_q <= sum;
        d_re_q <= diff;
      end
      if (ld_im) begin
        s_im_q <= sum;
        d_im_q <= diff;
      end
    end
  end

  assign s_re     = s_re_q;
  assign s_im     = s_im_q;
  assign d_re     = d_re_q;
  assign d_im     = d_im_q;
  assign bfly_cnt = cnt_q;

endmodule

// File: tb/tb_bfly_seq.sv
// Scoreboard bench for bfly_seq: a 16-bit-counter instance and a 2-bit-counter
// instance share all stimulus.
module tb_bfly_seq;

  typedef struct {
    logic [31:0] a_re, a_im, b_re, b_im;
    logic [31:0] s_re, s_im, d_re, d_im;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic        in_ready, out_valid, busy;
  logic [31:0] s_re, s_im, d_re, d_im;
  logic [15:0] bfly_cnt;
  logic        w_in_ready, w_out_valid, w_busy;
  logic [31:0] w_s_re, w_s_im, w_d_re, w_d_im;
  logic [1:0]  w_cnt;

  int   n_chk = 0, n_err = 0, cyc = 0, cnt_exp = 0;
  vec_t vt[6];
  vec_t cur_exp, e;
  vec_t sb[$];
  int   out_cyc[$];

  bfly_seq u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_re(s_re), .s_im(s_im), .d_re(d_re), .d_im(d_im),
    .busy(busy), .bfly_cnt(bfly_cnt)
  );

  bfly_seq #(.CNT_W(2)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .s_re(w_s_re), .s_im(w_s_im), .d_re(w_d_re), .d_im(w_d_im),
    .busy(w_busy), .bfly_cnt(w_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Handshakes are observed at the falling edge, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      cnt_exp = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underrun", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("s_re", s_re, e.s_re);
          chk("s_im", s_im, e.s_im);
          chk("d_re", d_re, e.d_re);
          chk("d_im", d_im, e.d_im);
          chk("w_s_re", w_s_re, e.s_re);
          chk("w_d_im", w_d_im, e.d_im);
        end
        chk("cnt_live", {16'd0, bfly_cnt}, cnt_exp & 32'hFFFF);
        chk("wcnt_live", {30'd0, w_cnt}, cnt_exp % 4);
        cnt_exp++;
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic send(input vec_t v, input bit align);
    int t = 0;
    if (align) begin
      @(posedge clk); #1;
    end
    a_re = v.a_re; a_im = v.a_im; b_re = v.b_re; b_im = v.b_im;
    cur_exp  = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    vt[0] = '{32'h40000000, 32'h3f800000, 32'h3f800000, 32'h3f000000,
              32'h40400000, 32'h3fc00000, 32'h3f800000, 32'h3f000000};
    vt[1] = '{32'h3f800000, 32'hbf800000, 32'h3f800000, 32'hbf800000,
              32'h40000000, 32'hc0000000, 32'h00000000, 32'h00000000};
    vt[2] = '{32'h7f7fffff, 32'h00000000, 32'h7f7fffff, 32'h00000000,
              32'hffffffff, 32'h00000000, 32'h00000000, 32'h00000000};
    vt[3] = '{32'h40a00000, 32'hc0400000, 32'h40400000, 32'h41000000,
              32'h41000000, 32'h40a00000, 32'h40000000, 32'hc1300000};
    vt[4] = '{32'h3f800000, 32'h00000000, 32'h40000000, 32'h3f800000,
              32'h40400000, 32'h3f800000, 32'hbf800000, 32'hbf800000};
    vt[5] = '{32'h3f800000, 32'h4b800000, 32'h33800000, 32'h3f800000,
              32'h3f800000, 32'h4b800000, 32'h3f7fffff, 32'h4b7fffff};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    cur_exp = vt[0];
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, bfly_cnt}, 32'd0);
    chk("rst_s_re", s_re, 32'd0);
    chk("rst_s_im", s_im, 32'd0);
    chk("rst_d_re", d_re, 32'd0);
    chk("rst_d_im", d_im, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_w_rdy", {31'd0, w_in_ready}, 32'd1);
    chk("rst_w_ov", {31'd0, w_out_valid}, 32'd0);
    chk("rst_w_busy", {31'd0, w_busy}, 32'd0);

    // basic butterfly and latency from the accept edge
    send(vt[0], 1'b1);
    @(negedge clk); chk("lat_e1", {31'd0, out_valid}, 32'd0);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("lat_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk); chk("lat_e2", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("lat_e3", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("basic_cnt", {16'd0, bfly_cnt}, 32'd1);
    chk("basic_idle", {31'd0, busy}, 32'd0);

    send(vt[1], 1'b1);
    drain();

    // backpressure in DONE
    @(posedge clk); #1 out_ready = 1'b0;
    send(vt[3], 1'b1);
    wait_ov("bp_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("bp_s_re", s_re, vt[3].s_re);
      chk("bp_s_im", s_im, vt[3].s_im);
      chk("bp_d_re", d_re, vt[3].d_re);
      chk("bp_d_im", d_im, vt[3].d_im);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_cnt", {16'd0, bfly_cnt}, 32'd2);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_cnt_inc", {16'd0, bfly_cnt}, 32'd3);
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // back-to-back with in_valid held through RE/IM
    do_reset();
    out_cyc.delete();
    send(vt[2], 1'b1);
    send(vt[4], 1'b0);
    send(vt[5], 1'b0);
    drain();
    if (out_cyc.size() == 3) begin
      chk("b2b_gap1", out_cyc[1] - out_cyc[0], 32'd3);
      chk("b2b_gap2", out_cyc[2] - out_cyc[1], 32'd3);
    end else begin
      chk("b2b_count", out_cyc.size(), 32'd3);
    end
    @(negedge clk);
    chk("b2b_cnt", {16'd0, bfly_cnt}, 32'd3);
    chk("b2b_w_cnt", {30'd0, w_cnt}, 32'd3);

    // reset while in IM
    send(vt[0], 1'b1);
    @(posedge clk); #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_cnt", {16'd0, bfly_cnt}, 32'd0);
    chk("mid_s_re", s_re, 32'd0);
    chk("mid_s_im", s_im, 32'd0);
    chk("mid_d_re", d_re, 32'd0);
    chk("mid_d_im", d_im, 32'd0);
    chk("mid_rdy", {31'd0, in_ready}, 32'd1);
    chk("mid_idle", {31'd0, busy}, 32'd0);

    // counter wrap on the 2-bit instance
    for (int i = 0; i < 5; i++) send(vt[i], 1'b1);
    drain();
    @(negedge clk);
    @(negedge clk);
    chk("wrap_w_cnt", {30'd0, w_cnt}, 32'd1);
    chk("wrap_cnt", {16'd0, bfly_cnt}, 32'd5);
    chk("end_sb", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
